// File: rtl/avalon_window_bridge.sv
// Avalon-MM window bridge: maps CPU byte addresses onto a RAM window, inserts wait states
// and blocks out-of-window accesses with a sticky fault. Define BRIDGE_STRICT_ALIGN_EN to fault misaligned accesses.
module avalon_window_bridge #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          WINDOW_BITS = 16,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    input  logic [3:0]  s_byteenable,
    output logic        s_waitrequest,
    output logic [31:0] s_readdata,
    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic        fault,
    output logic [31:0] fault_addr
);

    // state | meaning
    // IDLE  | no access in progress; a new request starts the wait-state timer
    // STALL | wait-state down-counter running, CPU held off
    // FWD   | access forwarded to RAM, or blocked and completed locally

    localparam logic [1:0]  IDLE  = 2'd0;
    localparam logic [1:0]  STALL = 2'd1;
    localparam logic [1:0]  FWD   = 2'd2;

    localparam logic [32:0] WIN_SIZE  = 33'd1 << WINDOW_BITS;
    localparam logic [31:0] WIN_MASK  = 32'(WIN_SIZE - 33'd1);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

    logic [1:0]  state, state_next;
    logic [3:0]  count, count_next;
    logic        fault_next;
    logic [31:0] fault_addr_next;

    logic [31:0] offset;
    logic        in_window, halt_fetch, req, misaligned, faulting, forwardable;
    logic        fwd_phase, active, done;

    assign offset     = s_address - BASE_ADDR;
    assign in_window  = {1'b0, offset} < WIN_SIZE;
    assign halt_fetch = (s_address == 32'h0);
    assign req        = s_read | s_write;

`ifdef BRIDGE_STRICT_ALIGN_EN
    assign misaligned = |s_address[1:0];
`else
    assign misaligned = 1'b0;
`endif

    assign faulting    = (!in_window && !halt_fetch) || (s_read && s_write) || misaligned;
    assign forwardable = in_window && !faulting;

    // With no wait states IDLE itself acts as the forwarding cycle, giving 1 + N latency.
    assign fwd_phase = (state == FWD) || (ZERO_WAIT && state == IDLE);
    assign active    = fwd_phase && req && !reset;
    assign done      = active && (!forwardable || !m_waitrequest);

    assign m_address    = offset & WIN_MASK;
    assign m_writedata  = s_writedata;
    assign m_byteenable = s_byteenable;

    always_comb begin
        m_read        = 1'b0;
        m_write       = 1'b0;
        s_waitrequest = 1'b0;
        s_readdata    = 32'h0;
        if (!reset) begin
            if (active) begin
                if (forwardable) begin
                    m_read        = s_read;
                    m_write       = s_write;
                    s_waitrequest = m_waitrequest;
                    if (!m_waitrequest)
                        s_readdata = m_readdata;
                end
            end else if (req) begin
                s_waitrequest = 1'b1;
            end
        end
    end

    always_comb begin
        state_next      = state;
        count_next      = count;
        fault_next      = fault;
        fault_addr_next = fault_addr;
        case (state)
            IDLE: begin
                if (req) begin
                    if (ZERO_WAIT) begin
                        if (!done)
                            state_next = FWD;
                    end else begin
                        state_next = STALL;
                        count_next = WAIT_LOAD;
                    end
                end
            end
            STALL: begin
                if (!req) begin
                    state_next = IDLE;
                    count_next = 4'd0;
                end else begin
                    count_next = count - 4'd1;
                    if (count == 4'd1)
                        state_next = FWD;
                end
            end
            FWD: begin
                if (!req || done)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (done && faulting && !fault) begin
            fault_next      = 1'b1;
            fault_addr_next = s_address;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 4'd0;
            fault      <= 1'b0;
            fault_addr <= 32'h0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            fault      <= fault_next;
            fault_addr <= fault_addr_next;
        end
    end

endmodule

// File: tb/tb_avalon_window_bridge.sv
// Directed self-checking bench for avalon_window_bridge (default parameters, WAIT_CYCLES = 2).
module tb_avalon_window_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_address;
    logic        s_read, s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic [31:0] m_address;
    logic        m_read, m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        fault;
    logic [31:0] fault_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    avalon_window_bridge dut (
        .clk           (clk),
        .reset         (reset),
        .s_address     (s_address),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_byteenable  (s_byteenable),
        .s_waitrequest (s_waitrequest),
        .s_readdata    (s_readdata),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_byteenable  (m_byteenable),
        .m_waitrequest (m_waitrequest),
        .m_readdata    (m_readdata),
        .fault         (fault),
        .fault_addr    (fault_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; inputs change here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // In-window read with a one-cycle RAM wait: 3 stall cycles, RAM-wait cycle, completion.
    task automatic rd_in(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] off);
        s_address = a; s_read = 1'b1; s_write = 1'b0;
        m_readdata = d; m_waitrequest = 1'b1;
        #4;
        check({tag, ".addr"}, m_address, off);
        check({tag, ".wr1"}, {31'b0, s_waitrequest}, 32'd1);
        check({tag, ".mrd1"}, {31'b0, m_read}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(); #4;
            check({tag, ".wr_stall"}, {31'b0, s_waitrequest}, 32'd1);
            check({tag, ".mrd_stall"}, {31'b0, m_read}, 32'd0);
        end
        step(); #4;
        check({tag, ".wr4"}, {31'b0, s_waitrequest}, 32'd1);
        check({tag, ".mrd4"}, {31'b0, m_read}, 32'd1);
        check({tag, ".rdata4"}, s_readdata, 32'h0);
        step(); m_waitrequest = 1'b0; #4;
        check({tag, ".wr5"}, {31'b0, s_waitrequest}, 32'd0);
        check({tag, ".mrd5"}, {31'b0, m_read}, 32'd1);
        check({tag, ".rdata5"}, s_readdata, d);
        step(); s_read = 1'b0; m_waitrequest = 1'b1; #4;
        check({tag, ".idle_mrd"}, {31'b0, m_read}, 32'd0);
        check({tag, ".idle_wr"}, {31'b0, s_waitrequest}, 32'd0);
        step();
    endtask

    // Blocked or halt-fetch access: 3 stall cycles then local completion, no RAM strobes.
    task automatic oow(input string tag, input logic [31:0] a, input logic rd, input logic wr);
        s_address = a; s_read = rd; s_write = wr;
        m_readdata = 32'hDEADBEEF; m_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #4;
            check({tag, ".wr_stall"}, {31'b0, s_waitrequest}, 32'd1);
            check({tag, ".strobes"}, {30'b0, m_read, m_write}, 32'd0);
            step();
        end
        #4;
        check({tag, ".wr_done"}, {31'b0, s_waitrequest}, 32'd0);
        check({tag, ".strobes_done"}, {30'b0, m_read, m_write}, 32'd0);
        check({tag, ".rdata_done"}, s_readdata, 32'h0);
        step(); s_read = 1'b0; s_write = 1'b0;
        #4;
        check({tag, ".idle_state"}, {30'b0, dut.state}, 32'd0);
        step();
    endtask

    initial begin
        reset = 1'b1;
        s_address = 32'hBFC00010; s_read = 1'b1; s_write = 1'b0;
        s_writedata = 32'hCAFEF00D; s_byteenable = 4'hF;
        m_waitrequest = 1'b1; m_readdata = 32'h0;

        step(); #4;
        check("rst.waitreq", {31'b0, s_waitrequest}, 32'd0);
        check("rst.mread", {31'b0, m_read}, 32'd0);
        check("rst.fault", {31'b0, fault}, 32'd0);
        check("rst.fault_addr", fault_addr, 32'h0);
        check("rst.maddr", m_address, 32'h10);
        check("rst.wdata", m_writedata, 32'hCAFEF00D);
        step(); reset = 1'b0; s_read = 1'b0;
        #4;
        check("idle.waitreq", {31'b0, s_waitrequest}, 32'd0);
        step();

        rd_in("rd10", 32'hBFC00010, 32'h12345678, 32'h10);
        check("rd10.fault", {31'b0, fault}, 32'd0);
        rd_in("rdlast", 32'hBFC0FFFC, 32'hA5A55A5A, 32'hFFFC);

        oow("halt", 32'h0, 1'b1, 1'b0);
        check("halt.fault", {31'b0, fault}, 32'd0);

        s_address = 32'hBFC00040; s_read = 1'b1;
        step(); s_read = 1'b0; #4;
        check("abort.mread", {31'b0, m_read}, 32'd0);
        check("abort.waitreq", {31'b0, s_waitrequest}, 32'd0);
        step(); #4;
        check("abort.state", {30'b0, dut.state}, 32'd0);
        check("abort.fault", {31'b0, fault}, 32'd0);
        step();
        rd_in("rd40", 32'hBFC00040, 32'h0BADF00D, 32'h40);

`ifdef BRIDGE_STRICT_ALIGN_EN
        oow("mis", 32'hBFC00002, 1'b1, 1'b0);
        check("mis.fault", {31'b0, fault}, 32'd1);
        check("mis.fault_addr", fault_addr, 32'hBFC00002);
`else
        rd_in("mis", 32'hBFC00002, 32'h77665544, 32'h2);
        check("mis.fault", {31'b0, fault}, 32'd0);
`endif

        s_address = 32'hBFC00020; s_read = 1'b1; m_waitrequest = 1'b1;
        #4;
        step(); #1;
        check("rststall.pre_state", {30'b0, dut.state}, 32'd1);
        reset = 1'b1; #1;
        check("rststall.mread", {31'b0, m_read}, 32'd0);
        check("rststall.waitreq", {31'b0, s_waitrequest}, 32'd0);
        check("rststall.state", {30'b0, dut.state}, 32'd0);
        check("rststall.fault", {31'b0, fault}, 32'd0);
        step(); reset = 1'b0;
        rd_in("rd20", 32'hBFC00020, 32'h13579BDF, 32'h20);

        s_writedata = 32'h11223344; s_byteenable = 4'h3;
        #1;
        check("wr.wdata", m_writedata, 32'h11223344);
        check("wr.ben", {28'b0, m_byteenable}, 32'h3);
        oow("wrout", 32'hBFC10000, 1'b0, 1'b1);
        check("wrout.fault", {31'b0, fault}, 32'd1);
        check("wrout.fault_addr", fault_addr, 32'hBFC10000);
        oow("rd1000", 32'h00001000, 1'b1, 1'b0);
        check("rd1000.fault", {31'b0, fault}, 32'd1);
        check("rd1000.fault_addr", fault_addr, 32'hBFC10000);

        reset = 1'b1;
        step(); reset = 1'b0;
        #4;
        check("rst2.fault", {31'b0, fault}, 32'd0);
        step();
        oow("both", 32'hBFC00000, 1'b1, 1'b1);
        check("both.fault", {31'b0, fault}, 32'd1);
        check("both.fault_addr", fault_addr, 32'hBFC00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
